// File: rtl/agc_gain_apply.sv
// Applies the AGC gain word to the I/Q sample stream: gains are staged and committed on frame
// boundaries, then each sample is multiplied, rounded half-up and saturated in a 3-stage pipeline.
module agc_gain_apply #(
  parameter int unsigned FRAC  = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    arst,
  input  logic [31:0]             gain,
  input  logic                    gain_valid,
  input  logic                    s_valid,
  input  logic                    s_sof,
  input  logic signed [15:0]      data_in_I,
  input  logic signed [15:0]      data_in_Q,
  output logic                    m_valid,
  output logic                    m_sof,
  output logic signed [15:0]      data_out_I,
  output logic signed [15:0]      data_out_Q,
  output logic [CNT_W-1:0]        sat_count,
  input  logic                    sat_clr,
  output logic [31:0]             active_gain
);

  localparam int unsigned DW = 16;
  localparam int unsigned GW = 32;
  localparam int unsigned PW = DW + GW + 1;

  localparam logic [GW-1:0]        UNITY   = GW'(1) << FRAC;
  localparam logic signed [PW-1:0] RND     = PW'(1) << (FRAC - 1);
  localparam logic signed [PW-1:0] SAT_MAX = PW'(32'sd32767);
  localparam logic signed [PW-1:0] SAT_MIN = PW'(-32'sd32768);

  typedef enum logic {IDLE, PENDING} state_t;

  state_t      state, state_nxt;
  logic [GW-1:0] staged, staged_nxt, active_nxt;

  logic                 v1, sof1;
  logic signed [DW-1:0] i1, q1;
  logic [GW-1:0]        g1;

  logic                 v2, sof2;
  logic signed [PW-1:0] p_i, p_q;

  logic [DW:0]          res_i, res_q;

  // Round half-up, shift, clip; MSB of the result flags a clip.
  function automatic logic [DW:0] round_sat(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] r;
    r = (p + RND) >>> FRAC;
    if (r > SAT_MAX) return {1'b1, 16'h7fff};
    if (r < SAT_MIN) return {1'b1, 16'h8000};
    return {1'b0, r[DW-1:0]};
  endfunction

  // Gain staging: a committing sof promotes staged; a same-cycle gain_valid re-arms PENDING.
  always_comb begin
    state_nxt  = state;
    staged_nxt = staged;
    active_nxt = active_gain;
    case (state)
      IDLE: begin
        if (gain_valid) begin
          staged_nxt = gain;
          state_nxt  = PENDING;
        end
      end
      PENDING: begin
        if (s_valid && s_sof) begin
          active_nxt = staged;
          state_nxt  = IDLE;
        end
        if (gain_valid) begin
          staged_nxt = gain;
          state_nxt  = PENDING;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state       <= IDLE;
      staged      <= UNITY;
      active_gain <= UNITY;
    end else begin
      state       <= state_nxt;
      staged      <= staged_nxt;
      active_gain <= active_nxt;
    end
  end

  always_comb begin
    res_i = round_sat(p_i);
    res_q = round_sat(p_q);
  end

  // S1 captures the post-commit gain so the sof sample already sees it.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      v1   <= 1'b0;
      sof1 <= 1'b0;
      i1   <= '0;
      q1   <= '0;
      g1   <= UNITY;
      v2   <= 1'b0;
      sof2 <= 1'b0;
      p_i  <= '0;
      p_q  <= '0;
    end else begin
      v1   <= s_valid;
      sof1 <= s_valid & s_sof;
      if (s_valid) begin
        i1 <= data_in_I;
        q1 <= data_in_Q;
        g1 <= active_nxt;
      end
      v2   <= v1;
      sof2 <= sof1;
      if (v1) begin
        p_i <= i1 * $signed({1'b0, g1});
        p_q <= q1 * $signed({1'b0, g1});
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      m_valid    <= 1'b0;
      m_sof      <= 1'b0;
      data_out_I <= '0;
      data_out_Q <= '0;
    end else begin
      m_valid <= v2;
      m_sof   <= sof2;
      if (v2) begin
        data_out_I <= res_i[DW-1:0];
        data_out_Q <= res_q[DW-1:0];
      end
    end
  end

  // Clear wins over an increment; the counter sticks at all-ones.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sat_count <= '0;
    end else if (sat_clr) begin
      sat_count <= '0;
    end else if (v2 && (res_i[DW] || res_q[DW]) && (sat_count != '1)) begin
      sat_count <= sat_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_agc_gain_apply.sv
// Scoreboard bench for agc_gain_apply: expected samples are queued at drive time from a
// reference gain model and compared, including cycle of arrival, when m_valid appears.
module tb_agc_gain_apply;

  localparam int unsigned CNT_W = 8;
  localparam logic [31:0] UNITY = 32'h0001_0000;

  logic clk = 1'b0;
  logic arst;
  logic [31:0] gain;
  logic gain_valid, s_valid, s_sof, sat_clr;
  logic signed [15:0] data_in_I, data_in_Q;
  logic m_valid, m_sof;
  logic signed [15:0] data_out_I, data_out_Q;
  logic [CNT_W-1:0] sat_count;
  logic [31:0] active_gain;

  always #5 clk = ~clk;

  agc_gain_apply #(.FRAC(16), .CNT_W(CNT_W)) dut (
    .clk(clk), .arst(arst), .gain(gain), .gain_valid(gain_valid),
    .s_valid(s_valid), .s_sof(s_sof), .data_in_I(data_in_I), .data_in_Q(data_in_Q),
    .m_valid(m_valid), .m_sof(m_sof), .data_out_I(data_out_I), .data_out_Q(data_out_Q),
    .sat_count(sat_count), .sat_clr(sat_clr), .active_gain(active_gain)
  );

  typedef struct {
    int                 due;
    bit                 sof;
    logic signed [15:0] i;
    logic signed [15:0] q;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic [31:0] m_act, m_stg;
  bit m_pend;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic signed [15:0] scale(input int x, input logic [31:0] g);
    longint p;
    p = longint'(x) * longint'({32'd0, g});
    p = (p + 64'sd32768) >>> 16;
    if (p > 64'sd32767) return 16'h7fff;
    if (p < -64'sd32768) return 16'h8000;
    return p[15:0];
  endfunction

  // Drive one cycle of stimulus and update the reference gain model.
  task automatic drive(input bit v, input bit sof, input int i, input int q,
                       input bit gv = 1'b0, input logic [31:0] g = 32'd0, input bit clr = 1'b0);
    bit commit;
    exp_t e;
    s_valid    = v;
    s_sof      = sof;
    data_in_I  = 16'(i);
    data_in_Q  = 16'(q);
    gain_valid = gv;
    gain       = g;
    sat_clr    = clr;
    commit = v && sof && m_pend;
    if (commit) m_act = m_stg;
    if (v) begin
      e.due = cyc + 3;
      e.sof = sof;
      e.i   = scale(i, m_act);
      e.q   = scale(q, m_act);
      sb.push_back(e);
    end
    if (gv) begin
      m_stg  = g;
      m_pend = 1'b1;
    end else if (commit) begin
      m_pend = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 0, 0);
  endtask

  always @(negedge clk) begin
    if (!arst) begin
      if (m_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_m_valid", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("latency", cyc, e.due);
          check("m_sof", m_sof, e.sof);
          check("data_out_I", data_out_I, e.i);
          check("data_out_Q", data_out_Q, e.q);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        check("missing_m_valid", m_valid, 1);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    arst = 1'b1;
    gain = '0; gain_valid = 0; s_valid = 0; s_sof = 0; sat_clr = 0;
    data_in_I = '0; data_in_Q = '0;
    m_act = UNITY; m_stg = UNITY; m_pend = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_sof", m_sof, 0);
    check("rst_data_I", data_out_I, 0);
    check("rst_data_Q", data_out_Q, 0);
    check("rst_sat_count", sat_count, 0);
    check("rst_active_gain", active_gain, UNITY);
    arst = 1'b0;
    @(posedge clk);
    #1;

    // T1 unity
    drive(1, 1, 5000, 3000);
    idle(4);

    // T2 staged mid-frame, committed at next sof
    drive(1, 0, 100, -200, 1'b1, 32'h0002_0000);
    drive(1, 0, 300, 400);
    check("t2_active_before", active_gain, UNITY);
    drive(1, 1, -7000, 2000);
    check("t2_active_after", active_gain, 32'h0002_0000);
    idle(4);

    // T3 saturation, clear, clear priority, sticky all-ones
    drive(0, 0, 0, 0, 1'b1, 32'h0008_0000);
    drive(1, 1, 5000, -7000);
    idle(4);
    check("t3_sat_one", sat_count, 1);
    drive(0, 0, 0, 0, 1'b0, 32'd0, 1'b1);
    check("t3_sat_clr", sat_count, 0);
    drive(1, 0, 5000, 0);
    idle(1);
    drive(0, 0, 0, 0, 1'b0, 32'd0, 1'b1);
    check("t3_clr_priority", sat_count, 0);
    idle(3);
    check("t3_clr_stays", sat_count, 0);
    for (int k = 0; k < (1 << CNT_W); k++) drive(1, 0, -5000, 7000);
    idle(4);
    check("t3_sat_sticky", sat_count, (1 << CNT_W) - 1);

    // T4 rounding, hold, zero gain
    drive(0, 0, 0, 0, 1'b1, 32'h0000_8000);
    drive(1, 1, 3, -3);
    drive(1, 0, 1000, -500);
    idle(4);
    check("t4_hold_valid", m_valid, 0);
    check("t4_hold_I", data_out_I, 500);
    check("t4_hold_Q", data_out_Q, -250);
    drive(0, 0, 0, 0, 1'b1, 32'd0);
    drive(1, 1, 1234, -999);
    drive(1, 0, 32767, -32768);
    idle(4);

    // T5 gain_valid colliding with a committing sof
    drive(0, 0, 0, 0, 1'b1, 32'h0001_8000);
    drive(1, 1, 400, -400, 1'b1, 32'h0003_0000);
    drive(1, 0, 100, -100);
    check("t5_active_a", active_gain, 32'h0001_8000);
    drive(1, 0, 20, -20);
    drive(1, 1, 100, -100);
    check("t5_active_b", active_gain, 32'h0003_0000);
    idle(4);

    // T6 reset during a continuous stream
    drive(1, 0, 100, 100, 1'b1, 32'h0002_0000);
    drive(1, 1, 200, -200);
    for (int k = 0; k < 4; k++) drive(1, 0, 10 * k + 1, -3 * k);
    #3;
    arst = 1'b1;
    #1;
    check("t6_m_valid_now", m_valid, 0);
    check("t6_active_unity", active_gain, UNITY);
    sb.delete();
    m_act = UNITY; m_stg = UNITY; m_pend = 1'b0;
    s_valid = 0; s_sof = 0; gain_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    arst = 1'b0;
    idle(2);
    drive(1, 0, 1111, -2222);
    idle(4);
    check("t6_active_after", active_gain, UNITY);

    idle(2);
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
